// File: rtl/alu.sv
// 8-bit registered ALU: sixteen arithmetic/logic/shift/compare operations,
// one result per clock, result and carry/status bit registered with latency 1.
// Optional feature: define ALU_ZERO_FLAG_EN to add the registered zero_flag
// output (high when the registered alu_out is all zeros).
// Reset is asynchronous and active-low; it clears the result and carry
// and sets zero_flag, without waiting for the clock.
module alu #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_select,
  output logic [DATA_W-1:0] alu_out,
  output logic              carry_out
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic              zero_flag
`endif
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } op_e;

  // Sum with carry in the top bit.
  function automatic logic [DATA_W:0] add_op(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Difference modulo 2^DATA_W; the top bit of the widened subtraction is
  // set exactly when x < y, which is the borrow.
  function automatic logic [DATA_W:0] sub_op(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  // Low half of the full product; carry flags any bit in the high half.
  function automatic logic [DATA_W:0] mul_op(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y);
    logic [2*DATA_W-1:0] prod;
    prod = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
    return {|prod[2*DATA_W-1:DATA_W], prod[DATA_W-1:0]};
  endfunction

  // Integer quotient; division by zero saturates to all ones with carry set.
  function automatic logic [DATA_W:0] div_op(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y);
    if (y == '0) begin
      return {1'b1, {DATA_W{1'b1}}};
    end
    return {1'b0, x / y};
  endfunction

  // Single-bit shifts and rotates; shifts report the bit shifted out.
  function automatic logic [DATA_W:0] shift_op(input op_e                op,
                                               input logic [DATA_W-1:0] x);
    logic [DATA_W:0] res;
    res = '0;
    case (op)
      OP_SHL:  res = {x[DATA_W-1], x[DATA_W-2:0], 1'b0};
      OP_SHR:  res = {x[0], 1'b0, x[DATA_W-1:1]};
      OP_ROL:  res = {1'b0, x[DATA_W-2:0], x[DATA_W-1]};
      OP_ROR:  res = {1'b0, x[0], x[DATA_W-1:1]};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Bitwise logic group; carry is always clear.
  function automatic logic [DATA_W:0] logic_op(input op_e                op,
                                               input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] res;
    res = '0;
    case (op)
      OP_AND:  res = x & y;
      OP_OR:   res = x | y;
      OP_XOR:  res = x ^ y;
      OP_NOR:  res = ~(x | y);
      OP_NAND: res = ~(x & y);
      OP_XNOR: res = ~(x ^ y);
      default: res = '0;
    endcase
    return {1'b0, res};
  endfunction

  // Unsigned comparisons produce a 0/1 result in the low bit.
  function automatic logic [DATA_W:0] cmp_op(input op_e                op,
                                             input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_GT:   hit = (x > y);
      OP_EQ:   hit = (x == y);
      default: hit = 1'b0;
    endcase
    return {1'b0, {(DATA_W-1){1'b0}}, hit};
  endfunction

  op_e             op;
  logic [DATA_W:0] nxt;
  logic [DATA_W-1:0] out_p1;
  logic              carry_p1;
  logic              zero_p1;

  assign op = op_e'(alu_select);

  // Select the {carry, result} pair for the current opcode.
  always_comb begin
    nxt = '0;
    case (op)
      OP_ADD:                         nxt = add_op(a, b);
      OP_SUB:                         nxt = sub_op(a, b);
      OP_MUL:                         nxt = mul_op(a, b);
      OP_DIV:                         nxt = div_op(a, b);
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: nxt = shift_op(op, a);
      OP_AND, OP_OR, OP_XOR,
      OP_NOR, OP_NAND, OP_XNOR:       nxt = logic_op(op, a, b);
      OP_GT, OP_EQ:                   nxt = cmp_op(op, a, b);
      default:                        nxt = '0;
    endcase
  end

  // --- stage p1: result register, cleared immediately by reset ---
  // Register result, carry and zero status on every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1   <= '0;
      carry_p1 <= 1'b0;
      zero_p1  <= 1'b1;
    end else begin
      out_p1   <= nxt[DATA_W-1:0];
      carry_p1 <= nxt[DATA_W];
      zero_p1  <= (nxt[DATA_W-1:0] == '0);
    end
  end

  assign alu_out   = out_p1;
  assign carry_out = carry_p1;

`ifdef ALU_ZERO_FLAG_EN
  assign zero_flag = zero_p1;
`else
  // The zero status register is optimised away when the port is absent.
  logic unused_zero;
  assign unused_zero = zero_p1;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: expected {carry, result} pairs are queued when
// an operation is driven and compared when the registered result appears.
// Build with +define+ALU_ZERO_FLAG_EN to also check zero_flag.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] alu_select;
  logic [7:0] alu_out;
  logic       carry_out;
`ifdef ALU_ZERO_FLAG_EN
  logic       zero_flag;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string    tag;
    logic [8:0] res;
  } sb_t;

  sb_t        sb[$];
  logic [8:0] last_exp;

  alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .alu_select (alu_select),
    .alu_out    (alu_out),
    .carry_out  (carry_out)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .zero_flag  (zero_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model written in integer arithmetic.
  function automatic logic [8:0] model(input int x, input int y, input int s);
    int         r;
    bit         c;
    logic [7:0] xv;
    logic [7:0] yv;
    xv = x[7:0];
    yv = y[7:0];
    r  = 0;
    c  = 0;
    case (s)
      0:  begin r = x + y; c = (r > 255); r = r % 256; end
      1:  begin r = (x - y + 256) % 256; c = (x < y); end
      2:  begin r = x * y; c = (r > 255); r = r % 256; end
      3:  begin if (y == 0) begin r = 255; c = 1; end else r = x / y; end
      4:  begin r = (x * 2) % 256; c = (x >= 128); end
      5:  begin r = x / 2; c = (x % 2 == 1); end
      6:  r = (x * 2) % 256 + x / 128;
      7:  r = x / 2 + (x % 2) * 128;
      8:  r = int'(xv & yv);
      9:  r = int'(xv | yv);
      10: r = int'(xv ^ yv);
      11: r = int'(~(xv | yv));
      12: r = int'(~(xv & yv));
      13: r = int'(~(xv ^ yv));
      14: r = (x > y) ? 1 : 0;
      default: r = (x == y) ? 1 : 0;
    endcase
    return {c, r[7:0]};
  endfunction

  // Sample registered outputs against the oldest queued expectation.
  task automatic sample_and_check();
    sb_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 16'(sb.size()), 16'd1);
      return;
    end
    e = sb.pop_front();
    check(e.tag, {7'd0, carry_out, alu_out}, {7'd0, e.res});
`ifdef ALU_ZERO_FLAG_EN
    check({e.tag, "_zf"}, {15'd0, zero_flag}, {15'd0, (e.res[7:0] == 8'h00)});
`endif
    last_exp = e.res;
  endtask

  // Drive one operation with a given expectation and check it after the edge.
  task automatic drive(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [3:0] s, input logic [8:0] exp);
    sb_t e;
    @(negedge clk);
    a          = x;
    b          = y;
    alu_select = s;
    e.tag      = tag;
    e.res      = exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    sample_and_check();
  endtask

  task automatic drive_model(input string tag, input logic [7:0] x, input logic [7:0] y,
                             input logic [3:0] s);
    drive(tag, x, y, s, model(int'(x), int'(y), int'(s)));
  endtask

  // Watchdog: the bench never hangs.
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [3:0] rs;
    sb_t        e;
    rst_n      = 1'b0;
    a          = 8'd0;
    b          = 8'd0;
    alu_select = 4'd0;
    last_exp   = 9'd0;

    // Reset state, with and without clock edges.
    #1;
    check("rst_async", {7'd0, carry_out, alu_out}, 16'd0);
`ifdef ALU_ZERO_FLAG_EN
    check("rst_zf", {15'd0, zero_flag}, 16'd1);
`endif
    a = 8'd200; b = 8'd100; alu_select = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", {7'd0, carry_out, alu_out}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-derived expectations.
    drive("add",     8'd150, 8'd142, 4'd0,  {1'b1, 8'h24});
    drive("sub",     8'd150, 8'd142, 4'd1,  {1'b0, 8'h08});
    drive("mul",     8'd150, 8'd142, 4'd2,  {1'b1, 8'h34});
    drive("div",     8'd150, 8'd142, 4'd3,  {1'b0, 8'h01});
    drive("div0",    8'd150, 8'd0,   4'd3,  {1'b1, 8'hFF});
    drive("shl",     8'h96,  8'd142, 4'd4,  {1'b1, 8'h2C});
    drive("shr",     8'h96,  8'd142, 4'd5,  {1'b0, 8'h4B});
    drive("rol",     8'h96,  8'd142, 4'd6,  {1'b0, 8'h2D});
    drive("ror",     8'h96,  8'd142, 4'd7,  {1'b0, 8'h4B});
    drive("and",     8'd150, 8'd142, 4'd8,  {1'b0, 8'h86});
    drive("or",      8'd150, 8'd142, 4'd9,  {1'b0, 8'h9E});
    drive("xor",     8'd150, 8'd142, 4'd10, {1'b0, 8'h18});
    drive("nor",     8'd150, 8'd142, 4'd11, {1'b0, 8'h61});
    drive("nand",    8'd150, 8'd142, 4'd12, {1'b0, 8'h79});
    drive("xnor",    8'd150, 8'd142, 4'd13, {1'b0, 8'hE7});
    drive("gt",      8'd150, 8'd142, 4'd14, {1'b0, 8'h01});
    drive("eq_ne",   8'd150, 8'd142, 4'd15, {1'b0, 8'h00});
    drive("eq",      8'd7,   8'd7,   4'd15, {1'b0, 8'h01});
    drive("xor_zero",8'h55,  8'h55,  4'd10, {1'b0, 8'h00});

    // Boundary vectors.
    drive("add_ff",  8'hFF,  8'h01,  4'd0,  {1'b1, 8'h00});
    drive("add_nc",  8'h7F,  8'h80,  4'd0,  {1'b0, 8'hFF});
    drive("sub_brw", 8'd3,   8'd5,   4'd1,  {1'b1, 8'hFE});
    drive("sub_eq",  8'd9,   8'd9,   4'd1,  {1'b0, 8'h00});
    drive("mul_max", 8'hFF,  8'hFF,  4'd2,  {1'b1, 8'h01});
    drive("mul_nc",  8'd15,  8'd17,  4'd2,  {1'b0, 8'hFF});
    drive("div_small",8'd3,  8'd200, 4'd3,  {1'b0, 8'h00});
    drive("shr_c",   8'h81,  8'h00,  4'd5,  {1'b1, 8'h40});
    drive("ror_wrap",8'h01,  8'h00,  4'd7,  {1'b0, 8'h80});
    drive("gt_eq",   8'd42,  8'd42,  4'd14, {1'b0, 8'h00});
    drive("gt_lt",   8'd1,   8'd200, 4'd14, {1'b0, 8'h00});

    // Mid-cycle input change must not disturb the registered outputs.
    drive("pre_hold", 8'd150, 8'd142, 4'd0, {1'b1, 8'h24});
    #2;
    a = 8'd1; b = 8'd1; alu_select = 4'd15;
    #1;
    check("hold_mid", {7'd0, carry_out, alu_out}, {7'd0, last_exp});

    // Reset between edges clears outputs at once; the pending op is dropped.
    drive("pre_rst", 8'd200, 8'd100, 4'd0, {1'b1, 8'h2C});
    #2;
    a = 8'd10; b = 8'd20; alu_select = 4'd9;
    rst_n = 1'b0;
    #1;
    check("rst_mid", {7'd0, carry_out, alu_out}, 16'd0);
`ifdef ALU_ZERO_FLAG_EN
    check("rst_mid_zf", {15'd0, zero_flag}, 16'd1);
`endif
    @(posedge clk);
    #1;
    check("rst_edge", {7'd0, carry_out, alu_out}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e.tag = "post_rst";
    e.res = {1'b0, 8'h1E};
    sb.push_back(e);
    @(posedge clk);
    #1;
    sample_and_check();

    // Random operations against the reference model.
    for (int i = 0; i < 64; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 4'($urandom_range(0, 15));
      if (i % 16 == 0) rb = 8'd0;
      drive_model($sformatf("rnd%0d_op%0d", i, rs), ra, rb, rs);
    end

    check("sb_drained", 16'(sb.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 a  input  8  operand A, unsigned.
REQ-004 b  input  8  operand B, unsigned.
REQ-005 alu_select  input  4  operation code, sampled every rising clk edge.
REQ-006 alu_out  output  8  registered result.
REQ-007 carry_out  output  1  registered carry/borrow/status bit.
REQ-008 zero_flag  output  1  registered, high when the registered alu_out is 8'h00; present only with ALU_ZERO_FLAG_EN.

Function
REQ-009 Each rising clk edge, with rst_n high, SHALL compute {carry_out, alu_out} from the current a, b and alu_select and register them; latency 1 cycle; no handshake; a new operation every cycle.
REQ-010 Opcode map SHALL be:
- 0: a+b; carry = bit 8 of the 9-bit sum.
- 1: a-b modulo 256; carry = borrow, 1 iff a<b.
- 2: low 8 bits of a*b; carry = 1 iff product[15:8] != 0.
- 3: a/b, integer quotient; b==0 -> out 8'hFF, carry 1; otherwise carry 0.
- 4: a<<1; carry = a[7].
- 5: a>>1, logical; carry = a[0].
- 6: rotate a left by 1; carry 0.
- 7: rotate a right by 1; carry 0.
- 8: a&b.
- 9: a|b.
- 10: a^b.
- 11: ~(a|b).
- 12: ~(a&b).
- 13: ~(a^b).
- 14: out 8'h01 if a>b (unsigned) else 8'h00.
- 15: out 8'h01 if a==b else 8'h00.
REQ-011 Carry SHALL be 0 for opcodes 6-15.
REQ-012 Arithmetic SHALL be unsigned; sum/difference/product wrap modulo 256 in alu_out, with overflow reported only via carry_out as above.
REQ-013 Outputs SHALL hold their last registered value between edges, regardless of input changes.
REQ-014 Input changes between edges SHALL have no effect on outputs until the next rising edge; no combinational path from inputs to outputs.

Reset
REQ-015 When rst_n is low, alu_out SHALL be 8'h00, carry_out 0 and zero_flag 1 (if present), immediately and without waiting for clk.
REQ-016 Reset asserted mid-operation SHALL discard the pending result; the first rising edge after rst_n deasserts SHALL register the then-current operation.

Configuration
REQ-017 With macro ALU_ZERO_FLAG_EN defined, port zero_flag SHALL exist and be registered in the same cycle as alu_out, equal to (next alu_out == 8'h00).
REQ-018 Without ALU_ZERO_FLAG_EN, port zero_flag SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-019 a=150, b=142, sel=0 -> after 1 edge: alu_out=8'h24 (36), carry_out=1; sel=1 -> alu_out=8'h08, carry_out=0.
REQ-020 a=150, b=142, sel=2 -> alu_out=8'h34, carry_out=1; sel=3 -> alu_out=8'h01, carry_out=0; b=0, sel=3 -> alu_out=8'hFF, carry_out=1.
REQ-021 a=8'h96, sel=4 -> alu_out=8'h2C, carry_out=1; sel=5 -> alu_out=8'h4B, carry_out=0; sel=6 -> alu_out=8'h2D; sel=7 -> alu_out=8'h4B.
REQ-022 a=150, b=142, sweep sel 8..15 -> alu_out = 8'h86, 8'h9E, 8'h18, 8'h61, 8'h79, 8'hE7, 8'h01, 8'h00; carry_out=0 throughout; a=b=7, sel=15 -> alu_out=8'h01.
REQ-023 Registering and reset: drive rst_n low between edges -> outputs go to 0 at once; change inputs mid-cycle -> outputs unchanged until the next edge.
REQ-024 Zero flag: with ALU_ZERO_FLAG_EN, a=b=8'h55, sel=10 -> alu_out=8'h00 and zero_flag=1 after 1 edge.
